cpu_timer: RTL and testbench



---
 rtl/waffle_timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/cpu_timer.sv | 80 ++++++++
 tb/tb_cpu_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/waffle_timer_pkg.sv
// Shared constants for the WAFFLE CPU timers: ctrl bit positions and
// the memory-mapped register addresses of the two timer instances.
package waffle_timer_pkg;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_LOAD    = 1;
  localparam int unsigned CTRL_RELOAD  = 2;
  localparam int unsigned CTRL_IE      = 3;
  localparam int unsigned CTRL_PSC_LSB = 4;
  localparam int unsigned CTRL_PSC_MSB = 6;

  localparam int unsigned T1_CTRL = 990;
  localparam int unsigned T1_SET  = 991;
  localparam int unsigned T1_READ = 992;
  localparam int unsigned T2_CTRL = 993;
  localparam int unsigned T2_SET  = 994;
  localparam int unsigned T2_READ = 995;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a tick whenever the low 2*psc bits of the
// counter are all ones, giving a tick period of 2^(2*psc) clocks.
module timer_prescaler #(
  parameter int PSC_LOG2_MAX = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] psc,
  output logic       tick
);

  logic [PSC_LOG2_MAX-1:0] cnt_q;
  logic [PSC_LOG2_MAX-1:0] cnt_d;
  logic [PSC_LOG2_MAX-1:0] mask;

  // Upper bits are not cleared on a tick, so a PSC change mid-count
  // fires on the first low-bit match rather than restarting the period.
  assign mask  = ~({PSC_LOG2_MAX{1'b1}} << {psc, 1'b0});
  assign tick  = ((cnt_q & mask) == mask);
  assign cnt_d = clr ? '0 : cnt_q + PSC_LOG2_MAX'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_timer.sv
// Memory-mapped 8-bit down-counting timer with level load, optional
// auto-reload and a one-clock expiry interrupt pulse.
module cpu_timer
  import waffle_timer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PSC_LOG2_MAX = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ctrl,
  input  logic [WIDTH-1:0] set,
  output logic [WIDTH-1:0] read,
  output logic             irq
);

  logic             en;
  logic             load;
  logic             reload;
  logic             ie;
  logic [2:0]       psc;
  logic             tick;
  logic             expiry;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] read_q;
  logic             irq_q;
  logic             irq_d;
  logic             unused_rsvd;

  assign en          = ctrl[CTRL_EN];
  assign load        = ctrl[CTRL_LOAD];
  assign reload      = ctrl[CTRL_RELOAD];
  assign ie          = ctrl[CTRL_IE];
  assign psc         = ctrl[CTRL_PSC_MSB:CTRL_PSC_LSB];
  assign unused_rsvd = ctrl[WIDTH-1];

  timer_prescaler #(
    .PSC_LOG2_MAX (PSC_LOG2_MAX)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load | ~en),
    .psc   (psc),
    .tick  (tick)
  );

  // A zero count is a resting state: it neither expires nor reloads.
  always_comb begin
    count_d = count_q;
    expiry  = 1'b0;
    if (load) begin
      count_d = set;
    end else if (en && tick) begin
      if (count_q == WIDTH'(1)) begin
        expiry  = 1'b1;
        count_d = reload ? set : '0;
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
    irq_d = expiry & ie;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      read_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      read_q  <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign read = read_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_cpu_timer.sv
// Self-checking bench for cpu_timer: directed scenarios plus randomized
// control traffic, compared every cycle against a behavioural model.
module tb_cpu_timer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ctrl;
  logic [7:0] set;
  logic [7:0] read;
  logic       irq;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_cnt;
  int m_pre;
  bit m_irq;

  cpu_timer #(
    .WIDTH        (8),
    .PSC_LOG2_MAX (14)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl),
    .set   (set),
    .read  (read),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of one rising edge, from the ctrl/set values held before it.
  task automatic model_edge();
    int psc;
    int period;
    bit tick;
    if (!rst_n) begin
      m_cnt = 0; m_pre = 0; m_irq = 0;
      return;
    end
    psc    = int'(ctrl[6:4]);
    period = 1 << (2 * psc);
    if (ctrl[1]) begin
      m_cnt = int'(set); m_pre = 0; m_irq = 0;
    end else if (!ctrl[0]) begin
      m_pre = 0; m_irq = 0;
    end else begin
      tick  = ((m_pre % period) == period - 1);
      m_pre = (m_pre + 1) % 16384;
      m_irq = 0;
      if (tick) begin
        if (m_cnt == 1) begin
          m_irq = ctrl[3];
          m_cnt = ctrl[2] ? int'(set) : 0;
        end else if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    $display("[TB] %s ctrl=%02h set=%0d read=%0d irq=%0b", tag, ctrl, set, read, irq);
    check_eq({tag, ".read"}, read, m_cnt);
    check_eq({tag, ".irq"}, irq, m_irq);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int exp_rl [6];
    int held;
    n_tests = 0;
    n_fail  = 0;
    m_cnt = 0; m_pre = 0; m_irq = 0;

    // Reset held with all control bits set
    rst_n = 1'b0;
    ctrl  = 8'hFF;
    set   = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.read", read, 0);
    check_eq("rst.irq", irq, 0);
    ctrl  = 8'h00;
    rst_n = 1'b1;
    run("idle", 3);

    // One-shot load and count-down
    ctrl = 8'h02; set = 8'd5;
    step("load5");
    check_eq("load5.const", read, 5);
    ctrl = 8'h09;
    for (int k = 4; k >= 0; k--) begin
      step("oneshot");
      check_eq("oneshot.const", read, k);
    end
    check_eq("oneshot.irq_at_zero", irq, 1);
    step("oneshot_after");
    check_eq("oneshot.no_more_irq", irq, 0);
    run("oneshot_idle", 4);

    // Auto-reload period of 3
    ctrl = 8'h02; set = 8'd3;
    step("rl_load");
    ctrl = 8'h0D;
    exp_rl = '{2, 1, 3, 2, 1, 3};
    for (int k = 0; k < 6; k++) begin
      step("reload");
      check_eq("reload.const", read, exp_rl[k]);
    end

    // Prescaler PSC=1 and PSC=2
    ctrl = 8'h02; set = 8'd2;
    step("psc1_load");
    ctrl = 8'h19;
    run("psc1", 12);
    ctrl = 8'h02;
    step("psc2_load");
    ctrl = 8'h29;
    run("psc2", 40);

    // IE masked auto-reload
    ctrl = 8'h02; set = 8'd2;
    step("mask_load");
    ctrl = 8'h05;
    for (int k = 0; k < 8; k++) begin
      step("masked");
      check_eq("masked.irq_const", irq, 0);
    end

    // Pause and resume
    ctrl = 8'h02; set = 8'd9;
    step("pause_load");
    ctrl = 8'h09;
    run("pre_pause", 3);
    held = int'(read);
    ctrl = 8'h08;
    for (int k = 0; k < 3; k++) begin
      step("paused");
      check_eq("paused.hold", read, held);
    end
    ctrl = 8'h09;
    run("resume", 4);

    // set=0 with reload never fires
    ctrl = 8'h02; set = 8'd0;
    step("zero_load");
    ctrl = 8'h0D;
    run("zero_reload", 6);

    // LOAD while counting freezes at set
    ctrl = 8'h02; set = 8'd20;
    step("ld_load");
    ctrl = 8'h09;
    run("ld_count", 3);
    ctrl = 8'h0B; set = 8'd7;
    for (int k = 0; k < 3; k++) begin
      step("ld_frozen");
      check_eq("ld_frozen.const", read, 7);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ctrl[0]   = ($urandom_range(0, 3) != 0);
        ctrl[1]   = ($urandom_range(0, 7) == 0);
        ctrl[2]   = 1'($urandom_range(0, 1));
        ctrl[3]   = 1'($urandom_range(0, 1));
        ctrl[6:4] = 3'($urandom_range(0, 2));
        ctrl[7]   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0)
        set = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      step("rand");
    end

    // Asynchronous reset while irq is high every cycle
    ctrl = 8'h02; set = 8'd1;
    step("ar_load");
    ctrl = 8'h0D;
    run("ar_count", 2);
    check_eq("ar.irq_high", irq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt = 0; m_pre = 0; m_irq = 0;
    check_eq("ar.read_async", read, 0);
    check_eq("ar.irq_async", irq, 0);
    step("ar_held");
    rst_n = 1'b1;
    ctrl  = 8'h00;
    run("ar_after", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
